// File: rtl/vec_alu_ctrl.sv
// Issue/writeback sequencer for vec_alu: decodes a core command, reads operands, runs the ALU, writes back.
// Optional EXEC watchdog is compiled in with `define VEC_ALU_CTRL_TIMEOUT_EN.
module vec_alu_ctrl #(
    parameter int VLEN           = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [5:0]      cmd_funct6,
    input  logic [4:0]      cmd_vs1,
    input  logic [4:0]      cmd_vs2,
    input  logic [4:0]      cmd_vd,
    input  logic [2:0]      cmd_vsew,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [VLEN-1:0] rf_rdata1,
    input  logic [VLEN-1:0] rf_rdata2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [VLEN-1:0] rf_wdata,
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [2:0]      alu_vsew,
    output logic [VLEN-1:0] alu_vs1,
    output logic [VLEN-1:0] alu_vs2,
    input  logic [VLEN-1:0] alu_vd,
    input  logic            alu_done,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_error
);

    // state | meaning:  IDLE accept | READ rf address | CAP operands | EXEC alu run | WB write | RESP respond
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAP,
        S_EXEC,
        S_WB,
        S_RESP
    } state_t;

    localparam logic [5:0] OP_VAND = 6'b001001;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       legal;
    logic       timeout_hit;
    logic [5:0] funct6_q;
    logic [4:0] vd_q;
    logic [2:0] vsew_q;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("vec_alu_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    assign accept = cmd_valid && cmd_ready;
    assign legal  = (cmd_funct6 == OP_VAND) && (cmd_vsew <= 3'd3);

`ifdef VEC_ALU_CTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] exec_cnt;

    // Held at zero outside EXEC so every EXEC entry starts counting from zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exec_cnt <= '0;
        end else if (state != S_EXEC) begin
            exec_cnt <= '0;
        end else begin
            exec_cnt <= exec_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_EXEC) && !alu_done
                         && (exec_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = legal ? S_READ : S_RESP;
                end
            end
            S_READ: state_nxt = S_CAP;
            S_CAP:  state_nxt = S_EXEC;
            S_EXEC: begin
                if (alu_done) begin
                    state_nxt = S_WB;
                end else if (timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_WB:   state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // All outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmd_ready  <= 1'b0;
            alu_run    <= 1'b0;
            rf_we      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            funct6_q   <= '0;
            vd_q       <= '0;
            vsew_q     <= '0;
            rf_raddr1  <= '0;
            rf_raddr2  <= '0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            alu_opcode <= '0;
            alu_vsew   <= '0;
            alu_vs1    <= '0;
            alu_vs2    <= '0;
        end else begin
            cmd_ready <= (state_nxt == S_IDLE);
            alu_run   <= (state_nxt == S_EXEC);
            rf_we     <= (state_nxt == S_WB);
            rsp_valid <= (state_nxt == S_RESP);

            if (accept) begin
                funct6_q  <= cmd_funct6;
                vd_q      <= cmd_vd;
                vsew_q    <= cmd_vsew;
                rf_raddr1 <= cmd_vs1;
                rf_raddr2 <= cmd_vs2;
                rsp_error <= !legal;
            end

            if (state == S_CAP) begin
                alu_vs1    <= rf_rdata1;
                alu_vs2    <= rf_rdata2;
                alu_opcode <= funct6_q;
                alu_vsew   <= vsew_q;
            end

            // rf_wdata doubles as the result register for the write-back cycle.
            if ((state == S_EXEC) && alu_done) begin
                rf_wdata <= alu_vd;
                rf_waddr <= vd_q;
            end

            if (timeout_hit) begin
                rsp_error <= 1'b1;
            end

            if ((state == S_RESP) && rsp_ready) begin
                rsp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_alu_ctrl.sv
// Directed bench for vec_alu_ctrl with a register-file model and a vand ALU stub of programmable latency.
module tb_vec_alu_ctrl;

    localparam int VLEN = 128;
`ifdef VEC_ALU_CTRL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [5:0]      cmd_funct6 = '0;
    logic [4:0]      cmd_vs1 = '0;
    logic [4:0]      cmd_vs2 = '0;
    logic [4:0]      cmd_vd = '0;
    logic [2:0]      cmd_vsew = '0;
    logic [4:0]      rf_raddr1;
    logic [4:0]      rf_raddr2;
    logic [VLEN-1:0] rf_rdata1;
    logic [VLEN-1:0] rf_rdata2;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [VLEN-1:0] rf_wdata;
    logic            alu_run;
    logic [5:0]      alu_opcode;
    logic [2:0]      alu_vsew;
    logic [VLEN-1:0] alu_vs1;
    logic [VLEN-1:0] alu_vs2;
    logic [VLEN-1:0] alu_vd;
    logic            alu_done;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic            rsp_error;

    int checks = 0;
    int failures = 0;
    int we_count = 0;
    int run_count = 0;
    int stub_delay = 0;
    logic            force_done = 1'b0;
    logic            stub_done = 1'b0;
    logic [15:0]     stub_cnt = '0;
    logic            pre_we = 1'b0;
    logic [4:0]      pre_addr = '0;
    logic [VLEN-1:0] pre_data = '0;
    logic [VLEN-1:0] rf [32];

    localparam logic [VLEN-1:0] V_A1  = {4{32'hFFFF0000}};
    localparam logic [VLEN-1:0] V_A2  = {4{32'h12345678}};
    localparam logic [VLEN-1:0] V_AND = {4{32'h12340000}};
    localparam logic [VLEN-1:0] V_B5  = {4{32'hA5A5F00F}};
    localparam logic [VLEN-1:0] V_B6  = {4{32'h0FF03C3C}};
    localparam logic [VLEN-1:0] V_BND = {4{32'h05A0300C}};

    always #5 clk = ~clk;

    assign alu_vd   = alu_vs1 & alu_vs2;
    assign alu_done = stub_done | force_done;

    // Register file (one-cycle read latency) and ALU stub: done rises stub_delay cycles after run; 0 = never.
    always @(posedge clk) begin
        rf_rdata1 <= rf[rf_raddr1];
        rf_rdata2 <= rf[rf_raddr2];
        if (pre_we) rf[pre_addr] <= pre_data;
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            we_count <= we_count + 1;
        end
        if (alu_run) run_count <= run_count + 1;
        if (!alu_run) begin
            stub_cnt  <= '0;
            stub_done <= 1'b0;
        end else begin
            stub_cnt  <= stub_cnt + 16'd1;
            stub_done <= (stub_delay != 0) && (int'(stub_cnt) == stub_delay - 1);
        end
    end

    vec_alu_ctrl #(.VLEN(VLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct6(cmd_funct6),
        .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_vsew(cmd_vsew),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_vsew(alu_vsew),
        .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_vd(alu_vd), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [VLEN-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Offers a command and returns one cycle after acceptance (cycle T+1).
    task automatic issue(input logic [5:0] f6, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [2:0] sew);
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL issue_wait_ready: cmd_ready=%0b after 50 cycles, required 1", cmd_ready);
        end
        cmd_funct6 = f6; cmd_vs1 = s1; cmd_vs2 = s2; cmd_vd = d; cmd_vsew = sew;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] ctl;
        resetn = 1'b0; rsp_ready = 1'b1;
        tick(); tick(); tick();
        ctl = {alu_run, rf_we, rsp_valid, rsp_error, alu_opcode, alu_vsew, rf_waddr, rf_raddr1, rf_raddr2};
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready: got %0b exp 0", cmd_ready); end
        checks++; if (ctl !== '0) begin failures++; $display("FAIL reset_ctl_outputs: got %0h exp 0", ctl); end
        checks++; if ((alu_vs1 | alu_vs2 | rf_wdata) !== '0) begin failures++; $display("FAIL reset_data_outputs: got %0h exp 0", alu_vs1 | alu_vs2 | rf_wdata); end
        resetn = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %0b exp 1", cmd_ready); end
    endtask

    task automatic test_vand();
        int we0;
        preload(5'd1, V_A1);
        preload(5'd2, V_A2);
        we0 = we_count; stub_delay = 4; rsp_ready = 1'b1;
        issue(6'b001001, 5'd1, 5'd2, 5'd3, 3'd2);
        checks++; if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin failures++; $display("FAIL vand_raddr: got %0h/%0h exp 1/2", rf_raddr1, rf_raddr2); end
        checks++; if ({cmd_ready, alu_run} !== 2'b00) begin failures++; $display("FAIL vand_read_ctl: got ready=%0b run=%0b exp 0/0", cmd_ready, alu_run); end
        tick();
        checks++; if (alu_run !== 1'b0) begin failures++; $display("FAIL vand_cap_run: got %0b exp 0", alu_run); end
        tick();
        checks++; if (alu_run !== 1'b1) begin failures++; $display("FAIL vand_t3_run: got %0b exp 1", alu_run); end
        checks++; if ({alu_vs1, alu_vs2} !== {V_A1, V_A2}) begin failures++; $display("FAIL vand_operands: got %0h %0h exp %0h %0h", alu_vs1, alu_vs2, V_A1, V_A2); end
        checks++; if ({alu_opcode, alu_vsew} !== {6'b001001, 3'd2}) begin failures++; $display("FAIL vand_op_sew: got %0h/%0h exp 9/2", alu_opcode, alu_vsew); end
        tick(); tick(); tick(); tick();
        checks++; if ({alu_run, alu_done, rf_we} !== 3'b110) begin failures++; $display("FAIL vand_done_cycle: got run/done/we=%0b exp 110", {alu_run, alu_done, rf_we}); end
        tick();
        checks++; if ({rf_we, alu_run, rsp_valid} !== 3'b100) begin failures++; $display("FAIL vand_wb_ctl: got we/run/rsp=%0b exp 100", {rf_we, alu_run, rsp_valid}); end
        checks++; if ({rf_waddr, rf_wdata} !== {5'd3, V_AND}) begin failures++; $display("FAIL vand_wb_data: got %0d %0h exp 3 %0h", rf_waddr, rf_wdata, V_AND); end
        tick();
        checks++; if ({rsp_valid, rsp_error, rf_we} !== 3'b100) begin failures++; $display("FAIL vand_rsp: got valid/err/we=%0b exp 100", {rsp_valid, rsp_error, rf_we}); end
        tick();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL vand_after_hs: got ready/valid=%0b exp 10", {cmd_ready, rsp_valid}); end
        checks++; if (we_count - we0 !== 1) begin failures++; $display("FAIL vand_we_pulses: got %0d exp 1", we_count - we0); end
        checks++; if (rf[3] !== V_AND) begin failures++; $display("FAIL vand_rf3: got %0h exp %0h", rf[3], V_AND); end
    endtask

    task automatic test_illegal();
        int we0, run0;
        we0 = we_count; run0 = run_count; stub_delay = 4; rsp_ready = 1'b1;
        issue(6'b000000, 5'd1, 5'd2, 5'd4, 3'd0);
        checks++; if ({rsp_valid, rsp_error, alu_run} !== 3'b110) begin failures++; $display("FAIL illegal_f6_rsp: got valid/err/run=%0b exp 110", {rsp_valid, rsp_error, alu_run}); end
        tick();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL illegal_after_hs: got ready/valid=%0b exp 10", {cmd_ready, rsp_valid}); end
        issue(6'b001001, 5'd1, 5'd2, 5'd4, 3'd4);
        checks++; if ({rsp_valid, rsp_error} !== 2'b11) begin failures++; $display("FAIL illegal_sew_rsp: got valid/err=%0b exp 11", {rsp_valid, rsp_error}); end
        tick();
        checks++; if (we_count !== we0 || run_count !== run0) begin failures++; $display("FAIL illegal_side_effects: got we=%0d run=%0d exp 0 0", we_count - we0, run_count - run0); end
    endtask

    task automatic test_overlap();
        int n;
        preload(5'd5, V_B5);
        preload(5'd6, V_B6);
        stub_delay = 3; rsp_ready = 1'b1;
        issue(6'b001001, 5'd5, 5'd6, 5'd5, 3'd3);
        tick(); tick();
        n = 0;
        while (!rf_we && n < 20) begin
            checks++;
            if ({alu_run, alu_vs1, alu_vs2} !== {1'b1, V_B5, V_B6}) begin failures++; $display("FAIL overlap_exec_stable: cycle %0d run=%0b vs1=%0h exp run=1 vs1=%0h", n, alu_run, alu_vs1, V_B5); end
            n++;
            tick();
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL overlap_exec_len: got %0d exp 4", n); end
        checks++; if ({rf_waddr, rf_wdata} !== {5'd5, V_BND}) begin failures++; $display("FAIL overlap_wb: got %0d %0h exp 5 %0h", rf_waddr, rf_wdata, V_BND); end
        tick(); tick();
        checks++; if (rf[5] !== V_BND) begin failures++; $display("FAIL overlap_rf5: got %0h exp %0h", rf[5], V_BND); end
    endtask

    task automatic test_hold();
        int n;
        stub_delay = 1; rsp_ready = 1'b0;
        issue(6'b001001, 5'd1, 5'd2, 5'd7, 3'd2);
        n = 0;
        while (!rsp_valid && n < 20) begin n++; tick(); end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_rsp_wait: got %0b exp 1", rsp_valid); end
        cmd_funct6 = 6'b000000; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_error} !== 3'b100) begin failures++; $display("FAIL hold_stable: cycle %0d valid/ready/err=%0b exp 100", i, {rsp_valid, cmd_ready, rsp_error}); end
            tick();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL hold_after_hs: got ready/valid=%0b exp 10", {cmd_ready, rsp_valid}); end
        checks++; if (rf[7] !== V_AND) begin failures++; $display("FAIL hold_rf7: got %0h exp %0h", rf[7], V_AND); end
    endtask

    task automatic test_done_outside_exec();
        int we0;
        we0 = we_count; stub_delay = 0; force_done = 1'b1;
        tick(); tick(); tick();
        checks++; if ({cmd_ready, rf_we, rsp_valid, alu_run} !== 4'b1000 || we_count !== we0) begin failures++; $display("FAIL idle_done_ignored: got ready/we/rsp/run=%0b exp 1000", {cmd_ready, rf_we, rsp_valid, alu_run}); end
        issue(6'b001001, 5'd1, 5'd2, 5'd8, 3'd1);
        tick(); tick();
        checks++; if (alu_run !== 1'b1) begin failures++; $display("FAIL minlat_run: got %0b exp 1", alu_run); end
        tick();
        force_done = 1'b0;
        checks++; if ({rf_we, rf_wdata} !== {1'b1, V_AND}) begin failures++; $display("FAIL minlat_wb: got we=%0b data=%0h exp 1 %0h", rf_we, rf_wdata, V_AND); end
        tick();
        checks++; if ({rsp_valid, rsp_error} !== 2'b10) begin failures++; $display("FAIL minlat_rsp_t5: got valid/err=%0b exp 10", {rsp_valid, rsp_error}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int we0, n;
        we0 = we_count; stub_delay = 2; rsp_ready = 1'b1;
        issue(6'b001001, 5'd1, 5'd2, 5'd11, 3'd2);
        n = 0;
        while (!rsp_valid && n < 20) begin n++; tick(); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_r1: got %0b exp 1", cmd_ready); end
        issue(6'b001001, 5'd5, 5'd6, 5'd12, 3'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin n++; tick(); end
        tick();
        checks++; if ({rf[11], rf[12]} !== {V_AND, V_BND}) begin failures++; $display("FAIL b2b_results: got %0h %0h exp %0h %0h", rf[11], rf[12], V_AND, V_BND); end
        checks++; if (we_count - we0 !== 2) begin failures++; $display("FAIL b2b_we_pulses: got %0d exp 2", we_count - we0); end
    endtask

    task automatic test_reset_mid_exec();
        int we0;
        logic [28:0] ctl;
        stub_delay = 0; rsp_ready = 1'b1;
        issue(6'b001001, 5'd1, 5'd2, 5'd9, 3'd2);
        tick(); tick(); tick(); tick();
        we0 = we_count;
        checks++; if (alu_run !== 1'b1) begin failures++; $display("FAIL rst_exec_run: got %0b exp 1", alu_run); end
        resetn = 1'b0;
        tick();
        ctl = {alu_run, rf_we, rsp_valid, rsp_error, alu_opcode, alu_vsew, rf_waddr, rf_raddr1, rf_raddr2};
        checks++; if ({cmd_ready, ctl} !== '0) begin failures++; $display("FAIL rst_exec_outputs: got ready=%0b ctl=%0h exp 0", cmd_ready, ctl); end
        checks++; if ((alu_vs1 | alu_vs2 | rf_wdata) !== '0) begin failures++; $display("FAIL rst_exec_data: got %0h exp 0", alu_vs1 | alu_vs2 | rf_wdata); end
        resetn = 1'b1;
        tick();
        checks++; if ({cmd_ready, alu_run} !== 2'b10) begin failures++; $display("FAIL rst_exec_release: got ready/run=%0b exp 10", {cmd_ready, alu_run}); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (we_count !== we0) begin failures++; $display("FAIL rst_exec_no_write: got %0d writes exp 0", we_count - we0); end
    endtask

`ifdef VEC_ALU_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int we0, n;
        we0 = we_count; stub_delay = 0; rsp_ready = 1'b0;
        issue(6'b001001, 5'd1, 5'd2, 5'd13, 3'd2);
        tick(); tick();
        n = 0;
        while (alu_run && n < 100) begin n++; tick(); end
        checks++; if (n !== 16) begin failures++; $display("FAIL timeout_run_cycles: got %0d exp 16", n); end
        checks++; if ({rsp_valid, rsp_error} !== 2'b11) begin failures++; $display("FAIL timeout_rsp: got valid/err=%0b exp 11", {rsp_valid, rsp_error}); end
        checks++; if (we_count !== we0) begin failures++; $display("FAIL timeout_no_write: got %0d writes exp 0", we_count - we0); end
        rsp_ready = 1'b1;
        tick();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL timeout_after_hs: got ready/valid=%0b exp 10", {cmd_ready, rsp_valid}); end
    endtask
`else
    task automatic test_long_exec();
        int n;
        stub_delay = 300; rsp_ready = 1'b1;
        issue(6'b001001, 5'd1, 5'd2, 5'd14, 3'd2);
        tick(); tick();
        n = 0;
        while (alu_run && n < 400) begin n++; tick(); end
        checks++; if (n !== 301) begin failures++; $display("FAIL long_exec_cycles: got %0d exp 301", n); end
        checks++; if ({rf_we, rf_wdata} !== {1'b1, V_AND}) begin failures++; $display("FAIL long_exec_wb: got we=%0b data=%0h exp 1 %0h", rf_we, rf_wdata, V_AND); end
        tick();
        checks++; if ({rsp_valid, rsp_error} !== 2'b10) begin failures++; $display("FAIL long_exec_rsp: got valid/err=%0b exp 10", {rsp_valid, rsp_error}); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_vand();
        test_illegal();
        test_overlap();
        test_hold();
        test_done_outside_exec();
        test_back_to_back();
        test_reset_mid_exec();
`ifdef VEC_ALU_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_long_exec();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
